// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared types for the pipeline hazard controller: the memory-wait FSM state
// and the operand-forward select encodings driven onto fwd_a / fwd_b.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;  // operand from register file
  localparam fwd_sel_t FWD_MEM  = 2'b01;  // operand from EX/MEM result
  localparam fwd_sel_t FWD_WB   = 2'b10;  // operand from MEM/WB result

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave).
//   master drives : id_valid, id_use_rs1/2, id_rs1/2, ex_rs1/2, ex_rd,
//                   ex_reg_en, ex_mem_rd, branch_taken, mem_busy
//   slave drives  : pc_stall, if_id_stall, if_id_flush, id_ex_stall,
//                   id_ex_bubble, ex_mem_stall, fwd_a, fwd_b, stall_cnt
// REG_ADDR_W / CNT_W must match the parameters of the attached hazard_ctrl.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  // Pipeline -> controller
  logic                  id_valid;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_en;
  logic                  ex_mem_rd;
  logic                  branch_taken;
  logic                  mem_busy;
  // Controller -> pipeline
  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  if_id_flush;
  logic                  id_ex_stall;
  logic                  id_ex_bubble;
  logic                  ex_mem_stall;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_en, ex_mem_rd, branch_taken, mem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_mem_stall, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_en, ex_mem_rd, branch_taken, mem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_mem_stall, fwd_a, fwd_b, stall_cnt
  );

endinterface : hazard_ctrl_if

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Forward select for one EX source operand. MEM-stage producer wins over
// WB-stage producer; register 0 is never forwarded.
// Ports:
//   i_ex_rs          EX source register
//   i_mem_rd/i_mem_we  MEM-stage destination / write enable
//   i_wb_rd/i_wb_we    WB-stage destination / write enable
//   o_sel            FWD_NONE / FWD_MEM / FWD_WB
// -----------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_we,
  output fwd_sel_t              o_sel
);

  // NOTE: o_sel gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_sel = FWD_NONE;
    if (i_ex_rs != '0) begin
      if (i_mem_we && (i_mem_rd == i_ex_rs))     o_sel = FWD_MEM;
      else if (i_wb_we && (i_wb_rd == i_ex_rs))  o_sel = FWD_WB;
    end
  end

endmodule : hazard_fwd_sel

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: memory-wait stall, branch redirect flush,
// load-use / RAW stall, operand forwarding and a saturating stall counter.
// Ports:
//   CLK    clock
//   rst_n  synchronous active-low reset; all outputs read 0 while low
//   bus    hazard_ctrl_if.slave (pipeline inputs, stall/flush/fwd outputs)
// Configuration:
//   HAZARD_CTRL_FWD_EN defined   : forwarding enabled, only load-use stalls.
//   HAZARD_CTRL_FWD_EN undefined : fwd_a/fwd_b stay 00, any EX or MEM RAW
//                                  match against an ID source stalls.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic          CLK,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

`ifdef HAZARD_CTRL_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  state_e                r_state;
  logic [REG_ADDR_W-1:0] r_mem_rd, r_wb_rd;
  logic                  r_mem_we, r_wb_we;
  logic                  r_pending;
  logic [CNT_W-1:0]      r_cnt;

  logic     w_mem_stall, w_redirect, w_hit_ex, w_hit_mem, w_raw, w_load_use;
  logic     w_pc_stall;
  fwd_sel_t w_sel_a, w_sel_b;

  // ID instruction reads a given non-zero register.
  function automatic logic id_reads(input logic [REG_ADDR_W-1:0] rd);
    return (rd != '0) &&
           ((bus.id_use_rs1 && (bus.id_rs1 == rd)) ||
            (bus.id_use_rs2 && (bus.id_rs2 == rd)));
  endfunction

  // The cycle mem_busy rises (still RUN) stalls exactly like MEM_WAIT, so the
  // stall is visible in the same cycle the memory reports not-ready.
  assign w_mem_stall = ((r_state == RUN)      && bus.mem_busy) ||
                       ((r_state == MEM_WAIT) && bus.mem_busy);

  assign w_redirect = !w_mem_stall && (bus.branch_taken || r_pending);

  assign w_hit_ex  = bus.ex_reg_en && id_reads(bus.ex_rd);
  assign w_hit_mem = r_mem_we      && id_reads(r_mem_rd);

  // With forwarding only a load in EX cannot be bypassed in time; without it
  // every in-flight producer ahead of WB must drain first.
  assign w_raw = bus.id_valid &&
                 (FWD_EN ? (bus.ex_mem_rd && w_hit_ex) : (w_hit_ex || w_hit_mem));

  assign w_load_use = !w_mem_stall && !w_redirect && w_raw;
  assign w_pc_stall = w_mem_stall || w_load_use;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_ex_rs (bus.ex_rs1),
    .i_mem_rd(r_mem_rd), .i_mem_we(r_mem_we),
    .i_wb_rd (r_wb_rd),  .i_wb_we (r_wb_we),
    .o_sel   (w_sel_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_ex_rs (bus.ex_rs2),
    .i_mem_rd(r_mem_rd), .i_mem_we(r_mem_we),
    .i_wb_rd (r_wb_rd),  .i_wb_we (r_wb_we),
    .o_sel   (w_sel_b)
  );

  // Outputs are gated by rst_n so they read 0 for the whole reset window,
  // including before the first reset edge has cleared the registers.
  assign bus.pc_stall     = rst_n && w_pc_stall;
  assign bus.if_id_stall  = rst_n && w_pc_stall;
  assign bus.id_ex_stall  = rst_n && w_mem_stall;
  assign bus.ex_mem_stall = rst_n && w_mem_stall;
  assign bus.if_id_flush  = rst_n && w_redirect;
  assign bus.id_ex_bubble = rst_n && (w_redirect || w_load_use);
  assign bus.fwd_a        = (rst_n && FWD_EN && !w_mem_stall) ? w_sel_a : FWD_NONE;
  assign bus.fwd_b        = (rst_n && FWD_EN && !w_mem_stall) ? w_sel_b : FWD_NONE;
  assign bus.stall_cnt    = rst_n ? r_cnt : '0;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; reset is sampled on CLK, not in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_mem_rd  <= '0;
      r_mem_we  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        RUN:      if (bus.mem_busy)  r_state <= MEM_WAIT;
        MEM_WAIT: if (!bus.mem_busy) r_state <= RUN;
        default:                     r_state <= RUN;
      endcase

      // EX/MEM and MEM/WB are frozen during a memory stall, so are trackers.
      if (!w_mem_stall) begin
        r_mem_rd <= bus.ex_rd;
        r_mem_we <= bus.ex_reg_en;
        r_wb_rd  <= r_mem_rd;
        r_wb_we  <= r_mem_we;
      end

      // A redirect arriving while frozen must survive until IF/ID can flush.
      if (w_mem_stall && bus.branch_taken) r_pending <= 1'b1;
      else if (w_redirect)                 r_pending <= 1'b0;

      if (w_pc_stall && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl. A second instance with a 2-bit
// counter mirrors the same inputs to exercise counter saturation. Expected
// values follow the build: forwarding enabled when HAZARD_CTRL_FWD_EN is set.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

`ifdef HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
  hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  sat_bus ();

  assign sat_bus.id_valid     = bus.id_valid;
  assign sat_bus.id_use_rs1   = bus.id_use_rs1;
  assign sat_bus.id_use_rs2   = bus.id_use_rs2;
  assign sat_bus.id_rs1       = bus.id_rs1;
  assign sat_bus.id_rs2       = bus.id_rs2;
  assign sat_bus.ex_rs1       = bus.ex_rs1;
  assign sat_bus.ex_rs2       = bus.ex_rs2;
  assign sat_bus.ex_rd        = bus.ex_rd;
  assign sat_bus.ex_reg_en    = bus.ex_reg_en;
  assign sat_bus.ex_mem_rd    = bus.ex_mem_rd;
  assign sat_bus.branch_taken = bus.branch_taken;
  assign sat_bus.mem_busy     = bus.mem_busy;

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .bus(bus.slave)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) u_sat (
    .CLK(CLK), .rst_n(rst_n), .bus(sat_bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic step();
    @(posedge CLK);
    #1;
    bus.id_valid = 1'b0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0;
    bus.ex_rd = '0; bus.ex_reg_en = 1'b0; bus.ex_mem_rd = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_busy = 1'b0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    bus.ex_rd = rd; bus.ex_reg_en = 1'b1; bus.ex_mem_rd = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with busy/branch/hazard inputs active: outputs must stay 0.
    step(); rst_n = 1'b0; bus.mem_busy = 1'b1; bus.branch_taken = 1'b1;
    ex_load(5'd5); bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5;
    settle();
    check("rst_pc_stall", bus.pc_stall, 0);
    step(); rst_n = 1'b0; bus.mem_busy = 1'b1; settle();
    check("rst_ex_mem_stall", bus.ex_mem_stall, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);

    // c0 idle after reset
    step(); rst_n = 1'b1; settle();
    check("c0_pc_stall", bus.pc_stall, 0);
    check("c0_fwd_a", bus.fwd_a, FWD_NONE);

    // c1 load x5 in EX, ID add reads x5 -> load-use stall
    step(); ex_load(5'd5); bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5;
    settle();
    check("lu_pc_stall", bus.pc_stall, 1);
    check("lu_if_id_stall", bus.if_id_stall, 1);
    check("lu_bubble", bus.id_ex_bubble, 1);
    check("lu_id_ex_stall", bus.id_ex_stall, 0);
    check("lu_flush", bus.if_id_flush, 0);

    // c2 bubble in EX, load now in MEM: stalls only without forwarding
    step(); bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5; settle();
    check("lu_c2_pc_stall", bus.pc_stall, FWD ? 0 : 1);

    // c3 load reached WB -> clear in both builds
    step(); bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5; settle();
    check("lu_c3_pc_stall", bus.pc_stall, 0);

    // c4 load to x0 with ID reading x0 -> no stall
    step(); ex_load(5'd0); bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd0;
    settle();
    check("x0_pc_stall", bus.pc_stall, 0);
    check("x0_bubble", bus.id_ex_bubble, 0);

    // c5 load x7, ID reads x7 through rs2; MEM tracker holds x0 with we=1
    step(); ex_load(5'd7); bus.id_valid = 1'b1; bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd7;
    settle();
    check("rs2_pc_stall", bus.pc_stall, 1);
    check("x0_no_fwd", bus.fwd_a, FWD_NONE);

    // c6 matching source but no valid ID instruction -> no stall
    step(); ex_load(5'd9); bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd9; settle();
    check("novalid_pc_stall", bus.pc_stall, 0);

    // c7 add x3 in EX, sub reads x3 in ID: ALU result, stalls only without fwd
    step(); bus.ex_rd = 5'd3; bus.ex_reg_en = 1'b1;
    bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd3; settle();
    check("alu_pc_stall", bus.pc_stall, FWD ? 0 : 1);

    // c8 sub in EX reads x3 (MEM) and x9 (WB)
    step(); bus.ex_rs1 = 5'd3; bus.ex_rs2 = 5'd9; bus.ex_rd = 5'd4; bus.ex_reg_en = 1'b1;
    settle();
    check("fwd_a_mem", bus.fwd_a, FWD ? FWD_MEM : FWD_NONE);
    check("fwd_b_wb", bus.fwd_b, FWD ? FWD_WB : FWD_NONE);

    // c9 x3 still consumed, now in WB
    step(); bus.ex_rs1 = 5'd3; settle();
    check("fwd_a_wb", bus.fwd_a, FWD ? FWD_WB : FWD_NONE);
    check("fwd_b_x0", bus.fwd_b, FWD_NONE);

    // c10..c12 x8 written twice: MEM copy must win over WB copy
    step(); bus.ex_rd = 5'd8; bus.ex_reg_en = 1'b1; settle();
    step(); bus.ex_rd = 5'd8; bus.ex_reg_en = 1'b1; settle();
    step(); bus.ex_rs1 = 5'd8; settle();
    check("fwd_mem_over_wb", bus.fwd_a, FWD ? FWD_MEM : FWD_NONE);

    // c13 redirect with a load-use hazard present -> flush wins, no stall
    step(); bus.branch_taken = 1'b1; ex_load(5'd5);
    bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5; settle();
    check("br_flush", bus.if_id_flush, 1);
    check("br_bubble", bus.id_ex_bubble, 1);
    check("br_pc_stall", bus.pc_stall, 0);

    // c14 idle: flush lasts one cycle, count reflects stalls so far
    step(); settle();
    check("br_flush_off", bus.if_id_flush, 0);
    check("cnt_run", bus.stall_cnt, FWD ? 2 : 4);

    // c15 mem_busy rises: memory stall pattern
    step(); bus.mem_busy = 1'b1; settle();
    check("mb_pc_stall", bus.pc_stall, 1);
    check("mb_id_ex_stall", bus.id_ex_stall, 1);
    check("mb_ex_mem_stall", bus.ex_mem_stall, 1);
    check("mb_bubble", bus.id_ex_bubble, 0);

    // c16 MEM_WAIT with branch -> pending, no flush yet
    step(); bus.mem_busy = 1'b1; bus.branch_taken = 1'b1; settle();
    check("mw_flush", bus.if_id_flush, 0);

    // c17 reset mid-MEM_WAIT
    step(); rst_n = 1'b0; bus.mem_busy = 1'b1; settle();
    check("rst_mw_pc_stall", bus.pc_stall, 0);
    check("rst_mw_ex_mem_stall", bus.ex_mem_stall, 0);
    check("rst_mw_cnt", bus.stall_cnt, 0);

    // c18 out of reset: RUN, pending redirect discarded, counter cleared
    step(); rst_n = 1'b1; settle();
    check("post_rst_pc_stall", bus.pc_stall, 0);
    check("post_rst_flush", bus.if_id_flush, 0);
    check("post_rst_cnt", bus.stall_cnt, 0);

    // c19..c22 mem_busy for 4 cycles, branch pulsed in the 2nd
    for (int i = 0; i < 4; i++) begin
      step(); bus.mem_busy = 1'b1; bus.ex_rd = 5'd6; bus.ex_reg_en = 1'b1;
      bus.branch_taken = (i == 1);
      settle();
      check("mb4_pc_stall", bus.pc_stall, 1);
      check("mb4_flush", bus.if_id_flush, 0);
    end
    check("sat_reach", sat_bus.stall_cnt, 3);

    // c23 first RUN cycle: pending redirect applied; trackers were held
    step(); bus.ex_rs1 = 5'd6; bus.ex_rd = 5'd6; bus.ex_reg_en = 1'b1; settle();
    check("pend_flush", bus.if_id_flush, 1);
    check("pend_bubble", bus.id_ex_bubble, 1);
    check("pend_pc_stall", bus.pc_stall, 0);
    check("mb4_cnt", bus.stall_cnt, 4);
    check("hold_fwd_a", bus.fwd_a, FWD_NONE);
    check("sat_hold", sat_bus.stall_cnt, 3);

    // c24 pending cleared; x6 now visible in MEM
    step(); bus.ex_rs1 = 5'd6; settle();
    check("pend_clear", bus.if_id_flush, 0);
    check("resume_fwd_a", bus.fwd_a, FWD ? FWD_MEM : FWD_NONE);

    // c25..c27 three more stall cycles with the small counter saturated
    for (int i = 0; i < 3; i++) begin
      step(); bus.mem_busy = 1'b1; settle();
    end
    step(); settle();
    check("cnt_after", bus.stall_cnt, 7);
    check("sat_stays", sat_bus.stall_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_hazard_ctrl
